// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and active-low hex font for seg_scan_ctrl
package seg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [6:0] seg_font(input logic [3:0] v);
    return FONT[v];
  endfunction
endpackage

// File: rtl/scan_tick.sv
// scan_tick: free-running SCAN_DIV prescaler with a wrap strobe on its last count
module scan_tick #(
  parameter int unsigned SCAN_DIV = 50000,
  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] o_cnt,
  output logic          o_wrap
);
  logic [CW-1:0] r_cnt;
  assign o_wrap = r_cnt == CW'(SCAN_DIV - 1);
  assign o_cnt  = r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: double-buffered 4-digit seven-segment scanner with guard blanking.
// Define SEG_BLINK_EN to build the per-digit blink logic.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GUARD        = 2,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           digit_val,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_start
);
  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  logic [CW-1:0]         w_cnt;
  logic                  w_wrap, w_fend, w_phase;
  logic [3:0]            w_dval;
  logic [1:0]            r_idx;
  logic                  r_pend;
  logic [15:0]           r_pd_val, r_sh_val;
  logic [NUM_DIGITS-1:0] r_pd_en, r_pd_blink, r_sh_en, r_sh_blink;
  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst),
    .o_cnt (w_cnt),
    .o_wrap(w_wrap)
  );
  assign w_fend = w_wrap && (r_idx == 2'd3);
  assign w_dval = r_sh_val[{r_idx, 2'b00} +: 4];
  // A load on the frame-end edge bypasses pending so it lands in the very next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx      <= '0;
      r_pend     <= 1'b0;
      r_pd_val   <= '0;
      r_pd_en    <= '0;
      r_pd_blink <= '0;
      r_sh_val   <= '0;
      r_sh_en    <= '0;
      r_sh_blink <= '0;
    end else begin
      if (w_wrap) r_idx <= r_idx + 2'd1;
      if (load) begin
        r_pd_val   <= digit_val;
        r_pd_en    <= digit_en;
        r_pd_blink <= blink_mask;
      end
      if (w_fend && load) begin
        r_sh_val   <= digit_val;
        r_sh_en    <= digit_en;
        r_sh_blink <= blink_mask;
        r_pend     <= 1'b0;
      end else if (w_fend && r_pend) begin
        r_sh_val   <= r_pd_val;
        r_sh_en    <= r_pd_en;
        r_sh_blink <= r_pd_blink;
        r_pend     <= 1'b0;
      end else if (load) begin
        r_pend <= 1'b1;
      end
    end
  end
`ifdef SEG_BLINK_EN
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] r_fcnt;
  logic          r_phase;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_fend) begin
      r_fcnt  <= (32'(r_fcnt) == BLINK_FRAMES - 1) ? '0 : r_fcnt + 1'b1;
      r_phase <= (32'(r_fcnt) == BLINK_FRAMES - 1) ? ~r_phase : r_phase;
    end
  end
  assign w_phase = r_phase;
`else
  assign w_phase = 1'b0 & |BLINK_FRAMES;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg         <= SEG_BLANK;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      seg         <= (!r_sh_en[r_idx] || (r_sh_blink[r_idx] && w_phase)) ? SEG_BLANK : seg_font(w_dval);
      an          <= (32'(w_cnt) < GUARD) ? 4'hF : ~(4'b0001 << r_idx);
      frame_start <= (r_idx == 2'd0) && (w_cnt == '0);
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed + random stimulus checked cycle-by-cycle against a frame-level model
module tb_seg_scan_ctrl;
  logic clk = 1'b0, rst = 1'b0, load = 1'b0;
  logic [15:0] digit_val = '0;
  logic [3:0]  digit_en = '0, blink_mask = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_start;
  int total = 0, bad = 0, k = 0;
  logic [15:0] m_val = '0, n_val = '0;
  logic [3:0]  m_en = '0, m_bl = '0, n_en = '0, n_bl = '0;
  bit          n_ok = 0;
  logic [6:0]  last_seg [4];
  localparam logic [6:0] F7 [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
`ifdef SEG_BLINK_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif
  seg_scan_ctrl #(.SCAN_DIV(8), .GUARD(2), .BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .digit_val  (digit_val),
    .digit_en   (digit_en),
    .blink_mask (blink_mask),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask
  // One clock: compare outputs for cycle k, then fold that cycle's load into the model.
  task automatic step();
    logic        l;
    logic [15:0] v;
    logic [3:0]  e, b, ae, dv;
    logic [6:0]  se;
    int          cn, ix, f;
    bit          ph;
    l = load; v = digit_val; e = digit_en; b = blink_mask;
    @(posedge clk);
    #1;
    cn = k % 8;
    ix = (k / 8) % 4;
    f  = k / 32;
    ph = BL && ((f / 2) % 2 == 1);
    dv = 4'(m_val >> (4 * ix));
    se = (!m_en[ix] || (m_bl[ix] && ph)) ? 7'h7F : F7[dv];
    ae = (cn < 2) ? 4'hF : ~(4'b0001 << ix);
    chk("an", 16'(an), 16'(ae));
    chk("frame_start", 16'(frame_start), 16'(k % 32 == 0));
    chk("seg", 16'(seg), 16'(se));
    for (int d = 0; d < 4; d++) if (an != 4'hF && !an[d]) last_seg[d] = seg;
    if (l) begin n_val = v; n_en = e; n_bl = b; n_ok = 1; end
    if (k % 32 == 31 && n_ok) begin m_val = n_val; m_en = n_en; m_bl = n_bl; n_ok = 0; end
    k++;
  endtask
  task automatic run_to(input int t);
    while (k < t) step();
  endtask
  task automatic pulse(input logic [15:0] v, input logic [3:0] e, input logic [3:0] b);
    digit_val = v; digit_en = e; blink_mask = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask
  task automatic chk_frame(input string tag, input logic [27:0] e);
    for (int d = 0; d < 4; d++) chk(tag, 16'(last_seg[d]), 16'(e[7*d +: 7]));
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_fs", 16'(frame_start), 16'h0);
    rst = 1'b1;
    run_to(40);
    pulse(16'h8570, 4'hF, 4'h0);
    run_to(64);
    chk_frame("hold", {7'h7F, 7'h7F, 7'h7F, 7'h7F});
    run_to(96);
    chk_frame("8570", {7'b0000000, 7'b0010010, 7'b1111000, 7'b1000000});
    run_to(127);
    pulse(16'h1234, 4'hF, 4'h0);
    run_to(160);
    chk_frame("coincide", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
    run_to(170);
    pulse(16'h1111, 4'hF, 4'h0);
    run_to(180);
    pulse(16'h2222, 4'hF, 4'h0);
    run_to(200);
    pulse(16'h8570, 4'hF, 4'b0010);
    run_to(224);
    chk_frame("overwrite", {7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100});
    run_to(256);
    chk_frame("blink_f7", {7'b0000000, 7'b0010010, BL ? 7'h7F : 7'b1111000, 7'b1000000});
    run_to(288);
    chk_frame("blink_f8", {7'b0000000, 7'b0010010, 7'b1111000, 7'b1000000});
    run_to(352);
    chk_frame("blink_f10", {7'b0000000, 7'b0010010, BL ? 7'h7F : 7'b1111000, 7'b1000000});
    for (int i = 0; i < 24; i++) begin
      run_to(k + int'($urandom_range(3, 40)));
      pulse(16'($urandom), 4'($urandom), 4'($urandom));
    end
    run_to(k + 64);
    pulse(16'hABCD, 4'hF, 4'h0);
    run_to((k / 32 + 2) * 32 + 20);
    rst = 1'b0;
    #1;
    chk("mid_rst_seg", 16'(seg), 16'h7F);
    chk("mid_rst_an", 16'(an), 16'hF);
    chk("mid_rst_fs", 16'(frame_start), 16'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    k = 0;
    m_val = '0; m_en = '0; m_bl = '0; n_ok = 0;
    run_to(64);
    chk_frame("post_rst", {7'h7F, 7'h7F, 7'h7F, 7'h7F});
    run_to(70);
    pulse(16'h0F0F, 4'hF, 4'h0);
    run_to(128);
    chk_frame("reload", {7'b1000000, 7'b0001110, 7'b1000000, 7'b0001110});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing controller for a 4-digit common-anode seven-segment display. It accepts four hex digit codes plus per-digit enable and blink masks, and double-buffers them so a frame never tears. It scans the shared segment bus across the digits, inserting guard blanking at each digit change. It sits between the switch/counter logic and the board's `seg`/`an` pins, replacing per-display hard-wired decode.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clock cycles per digit slot; must be ≥ `GUARD`+2.
- `GUARD`, 2: cycles at the start of each slot during which all anodes are off.
- `BLINK_FRAMES`, 64: frames per blink half-period. Only used with `SEG_BLINK_EN`.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-low.
- `digit_val` input 16: four 4-bit hex codes. Digit 0 = [3:0], digit 3 = [15:12].
- `digit_en` input 4: per-digit enable. A disabled digit is blanked.
- `blink_mask` input 4: per-digit blink select.
- `load` input 1: single-cycle strobe that captures `digit_val`/`digit_en`/`blink_mask`.
- `seg` output 7: active-low segments `{g,f,e,d,c,b,a}`, with bit0 = a. "0" = 7'b1000000.
- `an` output 4: active-low digit select, one-hot low.
- `frame_start` output 1: one-cycle pulse at the start of slot 0.

## Operation
- State:
  - slot counter `cnt`: 0..`SCAN_DIV`-1.
  - digit index `idx`: 0..3.
  - pending registers plus `pend` flag.
  - shadow registers (`sh_val`, `sh_en`, `sh_blink`).
  - blink frame counter and `blink_phase`.
- `cnt` increments every cycle. At `SCAN_DIV`-1 it wraps to 0, and `idx` advances 0→1→2→3→0 on the same edge.
- Frame end is the cycle with `idx`=3 and `cnt`=`SCAN_DIV`-1.
- Load path:
  - `load`=1 copies the inputs to the pending registers and sets `pend`.
  - Repeated loads within one frame: the last one wins.
- Shadow update:
  - On a frame-end edge with `pend`=1, pending is copied to shadow and `pend` is cleared.
  - If `load` coincides with frame end, the inputs go directly to shadow and `pend` stays 0.
- Output decode (registered; inputs taken from the current-cycle state):
  - `an` = 4'b1111 if `cnt` < `GUARD`, else ~(1<<`idx`).
  - `seg` = 7'h7F if `!sh_en[idx]`, or if `sh_blink[idx]` && `blink_phase`.
  - Otherwise `seg` = FONT(`sh_val[idx]`), covering 0–9 and A–F.
  - `frame_start` = 1 when `idx`=0 and `cnt`=0.
- Reset values:
  - `cnt`=0, `idx`=0, `pend`=0; all shadow/pending = 0; `blink_phase`=0.
  - `seg`=7'h7F, `an`=4'hF, `frame_start`=0.
- Reset asserted mid-frame forces all of the above immediately. The scan restarts at slot 0 after release.

## Timing
- Output latency: 1 cycle from state to `seg`/`an`/`frame_start`.
- First `frame_start` pulse: in cycle 1 after reset release.
- Frame period: 4×`SCAN_DIV` cycles. Each digit is driven for `SCAN_DIV`-`GUARD` cycles per frame.
- Load-to-display latency:
  - Data first appears at the `frame_start` following the next frame end.
  - Worst case: 4×`SCAN_DIV`+1 cycles after `load`.
- The segment value changes only on slot boundaries, and only while `an`=4'hF.

## Configuration
- `SEG_BLINK_EN` defined:
  - The frame counter counts frame ends; `blink_phase` toggles every `BLINK_FRAMES` frames.
  - `blink_mask` is honoured.
- `SEG_BLINK_EN` undefined:
  - No frame counter is built; `blink_phase` is tied to 0.
  - `blink_mask` is captured but ignored; enabled digits are always shown.

## Structure
- Package `seg_pkg`:
  - `SEG_BLANK` = 7'h7F.
  - `NUM_DIGITS` = 4.
  - 16-entry active-low `FONT` constant array and `seg_font()` function.
- Sub-module `scan_tick`:
  - Parameterised `SCAN_DIV` prescaler.
  - Outputs `cnt` and a `wrap` strobe.
- The top level holds the index, buffers, blink logic and output registers.

## Test plan
Bench parameters: `SCAN_DIV`=8, `GUARD`=2, `BLINK_FRAMES`=2.
- **Reset:** `rst`=0 → `seg`=7'h7F, `an`=4'hF, `frame_start`=0. After release, `frame_start`=1 in cycle 1 only, then every 32 cycles.
- **Guard/scan:** `an` = 1111 for exactly 2 cycles at each slot start, then 1110, 1101, 1011, 0111 (6 cycles each).
- **Decode and buffering:**
  - `load` `digit_val`=16'h8570, `digit_en`=4'hF, issued mid-frame.
  - The current frame is unchanged.
  - The next frame shows `seg` = 1000000, 1111000, 0010010, 0000000 for digits 0–3.
- **Coincidence/overwrite:**
  - `load` on the frame-end cycle → shown in the very next frame.
  - Two loads in one frame (16'h1111, then 16'h2222) → only 2222 is displayed.
- **Blink (`SEG_BLINK_EN`):** `blink_mask`=4'b0010 → digit 1 is shown in frames 0–1, blank in frames 2–3, shown in frames 4–5. Without the macro it is always shown.
- **Mid-frame reset:** assert `rst` during slot 2 → outputs blank within the same cycle and the shadow is cleared; after release, all digits stay blank until a new `load`.
